// File: rtl/bus_rr_arbiter_pkg.sv
// Shared constants, controller state encodings and index <-> one-hot helpers for the
// round-robin bus arbiter.
package bus_rr_arbiter_pkg;

    localparam int unsigned N_REQ  = 4;
    localparam int unsigned IDX_W  = 2;
    localparam int unsigned ADDR_W = 32;

    localparam logic [1:0] ARB_IDLE = 2'd0;
    localparam logic [1:0] ARB_ADDR = 2'd1;
    localparam logic [1:0] ARB_RESP = 2'd2;

    function automatic logic [3:0] decoder_2_4(input logic [1:0] idx);
        decoder_2_4 = 4'b0001 << idx;
    endfunction

    // Non-one-hot inputs (including zero) map to index 0.
    function automatic logic [1:0] encoder_4_2(input logic [3:0] onehot);
        unique case (onehot)
            4'b0010: encoder_4_2 = 2'd1;
            4'b0100: encoder_4_2 = 2'd2;
            4'b1000: encoder_4_2 = 2'd3;
            default: encoder_4_2 = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/bus_rr_arbiter_pick.sv
// Combinational round-robin picker: rotate requests so prio_ptr sits at bit 0, take the
// lowest set bit, then rotate the pick back into requester order.
module bus_rr_arbiter_pick
    import bus_rr_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] req_valid,
    input  logic [IDX_W-1:0] prio_ptr,
    output logic [N_REQ-1:0] winner,
    output logic             any_req
);

    logic [2*N_REQ-1:0] req_dbl;
    logic [2*N_REQ-1:0] pick_dbl;
    logic [N_REQ-1:0]   rot;
    logic [N_REQ-1:0]   pick;

    always_comb begin
        req_dbl  = {req_valid, req_valid} >> prio_ptr;
        rot      = req_dbl[N_REQ-1:0];
        // Isolate lowest set bit.
        pick     = rot & (~rot + N_REQ'(1));
        pick_dbl = {pick, pick} << prio_ptr;
        winner   = pick_dbl[2*N_REQ-1:N_REQ];
        any_req  = |req_valid;
    end

endmodule

// File: rtl/bus_rr_arbiter.sv
// Round-robin owner of the single memory bus port: one grant is held across the request
// handshake and the response handshake, then priority moves past the finished owner.
module bus_rr_arbiter
    import bus_rr_arbiter_pkg::*;
(
    input  logic                    clock,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    input  logic [N_REQ-1:0]        req_wen,
    output logic [N_REQ-1:0]        req_ready,
    output logic [N_REQ-1:0]        resp_valid,
    input  logic [N_REQ-1:0]        resp_ready,
    output logic                    bus_req_valid,
    input  logic                    bus_req_ready,
    output logic [ADDR_W-1:0]       bus_addr,
    output logic                    bus_wen,
    input  logic                    bus_resp_valid,
    output logic                    bus_resp_ready,
    output logic [IDX_W-1:0]        grant_idx,
    output logic                    busy
);

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] prio_ptr_q, prio_ptr_d;
    logic [IDX_W-1:0] grant_idx_q;
    logic [ADDR_W-1:0] bus_addr_q;
    logic             bus_wen_q;

    logic [N_REQ-1:0] winner;
    logic             any_req;
    logic [IDX_W-1:0] win_idx;
    logic [N_REQ-1:0] grant_mask;
    logic             capture;
    logic             in_addr;
    logic             in_resp;

    bus_rr_arbiter_pick u_pick (
        .req_valid (req_valid),
        .prio_ptr  (prio_ptr_q),
        .winner    (winner),
        .any_req   (any_req)
    );

    assign win_idx    = encoder_4_2(winner);
    assign grant_mask = decoder_2_4(grant_idx_q);
    assign capture    = (state_q == ARB_IDLE) && any_req;
    assign in_addr    = (state_q == ARB_ADDR);
    assign in_resp    = (state_q == ARB_RESP);

    always_comb begin
        state_d    = state_q;
        prio_ptr_d = prio_ptr_q;
        case (state_q)
            ARB_IDLE: if (any_req) state_d = ARB_ADDR;
            ARB_ADDR: if (bus_req_ready) state_d = ARB_RESP;
            ARB_RESP: begin
                if (bus_resp_valid && resp_ready[grant_idx_q]) begin
                    state_d    = ARB_IDLE;
                    prio_ptr_d = grant_idx_q + 2'd1;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        bus_req_valid  = in_addr;
        req_ready      = (in_addr && bus_req_ready) ? grant_mask : '0;
        resp_valid     = (in_resp && bus_resp_valid) ? grant_mask : '0;
        bus_resp_ready = in_resp && resp_ready[grant_idx_q];
        busy           = (state_q != ARB_IDLE);
        bus_addr       = bus_addr_q;
        bus_wen        = bus_wen_q;
        grant_idx      = grant_idx_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ARB_IDLE;
            prio_ptr_q  <= '0;
            grant_idx_q <= '0;
            bus_addr_q  <= '0;
            bus_wen_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            prio_ptr_q <= prio_ptr_d;
            if (capture) begin
                grant_idx_q <= win_idx;
                bus_addr_q  <= req_addr[win_idx*ADDR_W +: ADDR_W];
                bus_wen_q   <= req_wen[win_idx];
            end
        end
    end

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Directed bench for bus_rr_arbiter: single grant, round-robin order, stalls, response
// backpressure, asynchronous reset mid-transaction and pointer wrap.
module tb_bus_rr_arbiter;

    logic         clock;
    logic         reset;
    logic [3:0]   req_valid;
    logic [127:0] req_addr;
    logic [3:0]   req_wen;
    logic [3:0]   req_ready;
    logic [3:0]   resp_valid;
    logic [3:0]   resp_ready;
    logic         bus_req_valid;
    logic         bus_req_ready;
    logic [31:0]  bus_addr;
    logic         bus_wen;
    logic         bus_resp_valid;
    logic         bus_resp_ready;
    logic [1:0]   grant_idx;
    logic         busy;

    int checks;
    int failures;

    bus_rr_arbiter dut (
        .clock          (clock),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_addr       (req_addr),
        .req_wen        (req_wen),
        .req_ready      (req_ready),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .bus_req_valid  (bus_req_valid),
        .bus_req_ready  (bus_req_ready),
        .bus_addr       (bus_addr),
        .bus_wen        (bus_wen),
        .bus_resp_valid (bus_resp_valid),
        .bus_resp_ready (bus_resp_ready),
        .grant_idx      (grant_idx),
        .busy           (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_breqv"}, 64'(bus_req_valid), 64'd0);
        chk({tag, "_reqrdy"}, 64'(req_ready), 64'd0);
        chk({tag, "_respv"}, 64'(resp_valid), 64'd0);
        chk({tag, "_brsprdy"}, 64'(bus_resp_ready), 64'd0);
        chk({tag, "_gidx"}, 64'(grant_idx), 64'd0);
        chk({tag, "_baddr"}, 64'(bus_addr), 64'd0);
        chk({tag, "_bwen"}, 64'(bus_wen), 64'd0);
    endtask

    task automatic do_reset;
        reset = 1'b1;
        req_valid = '0;
        bus_req_ready = 1'b0;
        bus_resp_valid = 1'b0;
        resp_ready = '0;
        settle;
        check_quiet("rst");
        tick;
        tick;
        reset = 1'b0;
    endtask

    // One transaction with instant bus handshakes; takes exactly 3 cycles.
    task automatic run_txn(input logic [3:0] req, input logic [1:0] idx);
        logic [3:0] m;
        m = 4'b0001 << idx;
        req_valid = req;
        bus_req_ready = 1'b1;
        resp_ready = 4'hf;
        bus_resp_valid = 1'b0;
        settle;
        chk("txn_idle_busy", 64'(busy), 64'd0);
        tick;
        chk("txn_gidx", 64'(grant_idx), 64'(idx));
        chk("txn_breqv", 64'(bus_req_valid), 64'd1);
        chk("txn_reqrdy", 64'(req_ready), 64'(m));
        tick;
        chk("txn_resp_breqv", 64'(bus_req_valid), 64'd0);
        chk("txn_resp_busy", 64'(busy), 64'd1);
        bus_resp_valid = 1'b1;
        settle;
        chk("txn_respv", 64'(resp_valid), 64'(m));
        chk("txn_brsprdy", 64'(bus_resp_ready), 64'd1);
        tick;
        bus_resp_valid = 1'b0;
        settle;
        chk("txn_done_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        req_addr = '0;
        req_wen = '0;
        do_reset;

        // Single requester 2
        req_addr[2*32 +: 32] = 32'h8000_0010;
        req_wen = 4'b0100;
        req_valid = 4'b0100;
        bus_req_ready = 1'b1;
        resp_ready = 4'b0100;
        settle;
        chk("t1_pre_breqv", 64'(bus_req_valid), 64'd0);
        tick;
        chk("t1_breqv", 64'(bus_req_valid), 64'd1);
        chk("t1_baddr", 64'(bus_addr), 64'h8000_0010);
        chk("t1_bwen", 64'(bus_wen), 64'd1);
        chk("t1_gidx", 64'(grant_idx), 64'd2);
        chk("t1_reqrdy", 64'(req_ready), 64'b0100);
        req_valid = '0;
        tick;
        chk("t1_resp_breqv", 64'(bus_req_valid), 64'd0);
        bus_resp_valid = 1'b1;
        settle;
        chk("t1_respv", 64'(resp_valid), 64'b0100);
        chk("t1_brsprdy", 64'(bus_resp_ready), 64'd1);
        tick;
        bus_resp_valid = 1'b0;
        settle;
        chk("t1_done_busy", 64'(busy), 64'd0);

        // prio_ptr is now 3: 1001 must pick 3, then wrap to 0, then back to 3
        req_wen = '0;
        run_txn(4'b1001, 2'd3);
        run_txn(4'b1001, 2'd0);
        run_txn(4'b1001, 2'd3);

        // All requesting from reset
        do_reset;
        run_txn(4'b1111, 2'd0);
        run_txn(4'b1111, 2'd1);
        run_txn(4'b1111, 2'd2);
        run_txn(4'b1111, 2'd3);
        run_txn(4'b1111, 2'd0);

        // Stall in ADDR while requester 1 arrives
        do_reset;
        req_addr[0 +: 32] = 32'h1234_5678;
        req_valid = 4'b0001;
        resp_ready = 4'b0000;
        tick;
        chk("t3_gidx", 64'(grant_idx), 64'd0);
        req_valid = 4'b0011;
        req_addr[0 +: 32] = 32'hdead_beef;
        for (int i = 0; i < 5; i++) begin
            settle;
            chk("t3_stall_gidx", 64'(grant_idx), 64'd0);
            chk("t3_stall_baddr", 64'(bus_addr), 64'h1234_5678);
            chk("t3_stall_reqrdy", 64'(req_ready), 64'd0);
            chk("t3_stall_breqv", 64'(bus_req_valid), 64'd1);
            tick;
        end
        bus_req_ready = 1'b1;
        settle;
        chk("t3_accept_reqrdy", 64'(req_ready), 64'b0001);
        tick;
        bus_req_ready = 1'b0;

        // Response backpressure from owner 0
        bus_resp_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle;
            chk("t4_bp_brsprdy", 64'(bus_resp_ready), 64'd0);
            chk("t4_bp_respv", 64'(resp_valid), 64'b0001);
            chk("t4_bp_busy", 64'(busy), 64'd1);
            tick;
        end
        resp_ready = 4'b0001;
        settle;
        chk("t4_brsprdy", 64'(bus_resp_ready), 64'd1);
        tick;
        bus_resp_valid = 1'b0;
        settle;
        chk("t4_done_busy", 64'(busy), 64'd0);
        tick;
        chk("t4_next_gidx", 64'(grant_idx), 64'd1);
        chk("t4_next_breqv", 64'(bus_req_valid), 64'd1);

        // Async reset while owner 3 is in RESP
        do_reset;
        req_addr[3*32 +: 32] = 32'hcafe_0003;
        req_wen = 4'b1000;
        req_valid = 4'b1000;
        bus_req_ready = 1'b1;
        resp_ready = 4'hf;
        tick;
        chk("t5_gidx", 64'(grant_idx), 64'd3);
        req_valid = '0;
        tick;
        bus_resp_valid = 1'b1;
        settle;
        chk("t5_pre_respv", 64'(resp_valid), 64'b1000);
        reset = 1'b1;
        settle;
        check_quiet("t5_async");
        tick;
        reset = 1'b0;
        bus_resp_valid = 1'b0;
        req_wen = '0;
        req_valid = 4'b1001;
        settle;
        chk("t5_idle_busy", 64'(busy), 64'd0);
        tick;
        chk("t5_regrant_gidx", 64'(grant_idx), 64'd0);
        chk("t5_regrant_breqv", 64'(bus_req_valid), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
